// File: rtl/fetch_align_queue_pkg.sv
// Shared decode definitions: byte geometry and instruction-register byte ordering.
package fetch_align_queue_pkg;

    localparam int unsigned LINE_BYTES    = 16;
    localparam int unsigned BUF_BYTES     = 32;
    localparam int unsigned MAX_INSTR_LEN = 15;
    localparam int unsigned LEN_W         = $clog2(MAX_INSTR_LEN + 1);
    localparam int unsigned LINE_W        = LINE_BYTES * 8;

    // IR ordering: byte k (k = 0 oldest) sits at [LINE_W-1-8k -: 8].
    function automatic logic [7:0] ir_byte(input logic [LINE_W-1:0] ir, input int unsigned k);
        return ir[LINE_W - 1 - 8 * k -: 8];
    endfunction

endpackage

// File: rtl/fetch_byte_shifter.sv
// Byte-granular left shift toward byte0; vacated low bytes fill with zero.
module fetch_byte_shifter
    import fetch_align_queue_pkg::*;
#(
    parameter int unsigned BYTES   = BUF_BYTES,
    parameter int unsigned SHAMT_W = $clog2(BYTES)
) (
    input  logic [BYTES*8-1:0] data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [BYTES*8-1:0] shifted_c
);

    // Shift by whole bytes.
    always_comb begin
        shifted_c = data << {shamt, 3'b000};
    end

endmodule

// File: rtl/fetch_align_queue.sv
// Fetch-to-decode byte queue: aligns fetched lines, presents a 16-byte decode window.
module fetch_align_queue
    import fetch_align_queue_pkg::*;
#(
    parameter int unsigned LINE_BYTES = fetch_align_queue_pkg::LINE_BYTES,
    parameter int unsigned BUF_BYTES  = fetch_align_queue_pkg::BUF_BYTES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            line_valid,
    input  logic [LINE_BYTES*8-1:0]         line_data,
    output logic                            line_ready,
    input  logic                            flush,
    input  logic [$clog2(LINE_BYTES)-1:0]   flush_offset,
    output logic [LINE_BYTES*8-1:0]         ir,
    output logic [$clog2(LINE_BYTES+1)-1:0] ir_count,
    input  logic                            consume,
    input  logic [LEN_W-1:0]                consume_len,
    output logic                            consume_err
);

    localparam int unsigned LW   = LINE_BYTES * 8;
    localparam int unsigned BW   = BUF_BYTES * 8;
    localparam int unsigned CW   = $clog2(BUF_BYTES + 1);
    localparam int unsigned IW   = $clog2(LINE_BYTES + 1);
    localparam int unsigned OW   = $clog2(LINE_BYTES);
    localparam int unsigned SW   = $clog2(BUF_BYTES);

    logic [BW-1:0] data_q, data_n;
    logic [CW-1:0] count_q, count_n;
    logic [OW-1:0] skip_q, skip_n;
    logic [IW-1:0] ir_count_q, ir_count_n;
    logic          err_q, err_n;

    logic          consume_ok_c;
    logic          accept_c;
    logic [SW-1:0] consume_shamt_c;
    logic [BW-1:0] kept_c;
    logic [BW-1:0] line_aligned_c;
    logic [BW-1:0] appended_c;
    logic [CW-1:0] cnt_kept_c;
    logic [CW-1:0] line_len_c;

    // Handshake and consume legality from registered state only.
    always_comb begin
        line_ready      = (count_q <= CW'(LINE_BYTES)) && !flush;
        accept_c        = line_valid && line_ready;
        consume_ok_c    = consume && (consume_len != '0) && (IW'(consume_len) <= ir_count_q);
        consume_shamt_c = consume_ok_c ? SW'(consume_len) : '0;
    end

    fetch_byte_shifter #(.BYTES(BUF_BYTES), .SHAMT_W(SW)) u_consume_shift (
        .data      (data_q),
        .shamt     (consume_shamt_c),
        .shifted_c (kept_c)
    );

    fetch_byte_shifter #(.BYTES(BUF_BYTES), .SHAMT_W(SW)) u_skip_shift (
        .data      ({line_data, (BW - LW)'(0)}),
        .shamt     (SW'(skip_q)),
        .shifted_c (line_aligned_c)
    );

    // Next-state: flush wins, otherwise consume then append behind survivors.
    always_comb begin
        cnt_kept_c = consume_ok_c ? (count_q - CW'(consume_len)) : count_q;
        line_len_c = CW'(LINE_BYTES) - CW'(skip_q);
        appended_c = line_aligned_c >> {cnt_kept_c, 3'b000};

        data_n  = kept_c;
        count_n = cnt_kept_c;
        skip_n  = skip_q;
        err_n   = consume && !consume_ok_c;

        if (flush) begin
            data_n  = '0;
            count_n = '0;
            skip_n  = flush_offset;
            err_n   = 1'b0;
        end else if (accept_c) begin
            data_n  = kept_c | appended_c;
            count_n = cnt_kept_c + line_len_c;
            skip_n  = '0;
        end

        ir_count_n = (count_n > CW'(LINE_BYTES)) ? IW'(LINE_BYTES) : IW'(count_n);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            count_q    <= '0;
            skip_q     <= '0;
            ir_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            data_q     <= data_n;
            count_q    <= count_n;
            skip_q     <= skip_n;
            ir_count_q <= ir_count_n;
            err_q      <= err_n;
        end
    end

    assign ir          = data_q[BW-1 -: LW];
    assign ir_count    = ir_count_q;
    assign consume_err = err_q;

endmodule

// File: doc/fetch_align_queue.md
FETCH_ALIGN_QUEUE -- requirements
Module: fetch_align_queue

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 16, meaning bytes per fetched line and per decode window.
REQ-002 SHALL have parameter BUF_BYTES, default 32, meaning total byte storage (2 lines).
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous reset, active-high.
REQ-006 line_valid  input  1  fetch presents a 16-byte aligned line.
REQ-007 line_data  input  128  line bytes; byte0 at [127:120], byte15 at [7:0].
REQ-008 line_ready  output  1  queue accepts a line this cycle.
REQ-009 flush  input  1  redirect: discard all buffered bytes.
REQ-010 flush_offset  input  4  byte offset of the target within the next accepted line.
REQ-011 ir  output  128  decode window; byte0 (oldest) at [127:120]; bytes at or beyond ir_count are zero.
REQ-012 ir_count  output  5  valid bytes in ir, 0..16.
REQ-013 consume  input  1  decode retires an instruction this cycle.
REQ-014 consume_len  input  4  instruction length in bytes, legal 1..15.
REQ-015 consume_err  output  1  one-cycle pulse on an illegal consume.

Function
REQ-016 SHALL hold byte occupancy count in 0..32; ir_count = min(count,16).
REQ-017 line_ready SHALL be 1 iff count <= 16 and flush = 0 (combinational from registered count).
REQ-018 Line accepted iff line_valid & line_ready; it appends 16 - skip bytes, dropping its first skip bytes, where skip is the registered pending offset.
REQ-019 skip SHALL clear to 0 on the first line accepted after it is set.
REQ-020 Consume legal iff 1 <= consume_len <= ir_count; a legal consume removes consume_len oldest bytes and shifts remaining bytes toward byte0.
REQ-021 Illegal consume (len 0 or len > ir_count) SHALL leave state unchanged and assert consume_err for exactly the next cycle.
REQ-022 Simultaneous legal consume and line accept: new count = count - consume_len + (16 - skip); appended bytes follow the surviving bytes.
REQ-023 flush SHALL take priority: count <= 0, skip <= flush_offset, same-cycle line and consume ignored, consume_err not asserted.
REQ-024 ir and ir_count SHALL be registered-state outputs; data accepted in cycle N is visible in cycle N+1.
REQ-025 Consume bytes SHALL never cross into unwritten storage; storage beyond count reads zero.

Reset
REQ-026 On rst: count = 0, skip = 0, ir = 0, ir_count = 0, consume_err = 0; line_ready = 1 once rst deasserts.
REQ-027 Reset asserted mid-operation SHALL discard all buffered bytes immediately, regardless of pending consume or line.

Structure
REQ-028 LINE_BYTES, BUF_BYTES, MAX_INSTR_LEN = 15 and the IR byte-ordering definition SHALL live in the shared decode package.
REQ-029 Byte left-shift-by-N (32-byte, 5-bit shift amount) SHALL be a sub-module fetch_byte_shifter, used for both consume and skip alignment.
REQ-030 Storage SHALL be one 256-bit register plus 6-bit count and 4-bit skip registers.

Verification
REQ-031 Reset, then line 00..0F with skip 0 -> next cycle ir_count = 16, ir = 0x000102..0F, line_ready = 1.
REQ-032 flush with offset 5, then line 10..1F -> ir_count = 11, ir[127:120] = 0x15, low 40 bits zero.
REQ-033 count 16, consume_len 3 with line 20..2F accepted in the same cycle -> count 29, ir starts with byte 3 of the old window, line_ready = 0.
REQ-034 ir_count 4, consume_len 6 -> state unchanged, consume_err high for one cycle; consume_len 0 gives the same response.
REQ-035 count 32, line_valid held high -> line_ready = 0, no line accepted; consume_len 15 -> count 17, still not ready; consume_len 1 -> count 16, ready.
REQ-036 flush, consume_len 4 and line_valid all in one cycle -> count 0, skip = flush_offset, consume_err = 0.
